// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command sequencer:
//   - 4-bit ALU opcode constants (OP_ADD .. OP_NAND)
//   - command payload layout {a, b, op} as a packed struct
//   - sequencer FSM state encoding
//   - zero-divisor detection helper
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int CMD_W  = 3 * DATA_W;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_MOD  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1000;
    localparam logic [3:0] OP_SHL  = 4'b1001;
    localparam logic [3:0] OP_SHR  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_ROL  = 4'b1100;
    localparam logic [3:0] OP_ROR  = 4'b1101;
    localparam logic [3:0] OP_NOR  = 4'b1110;
    localparam logic [3:0] OP_NAND = 4'b1111;

    // Field order matches the FIFO payload bit order: a in [11:8], op in [3:0].
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] op;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    // Divide and modulo by zero are flagged instead of trusting the ALU result.
    function automatic logic is_zero_div(input logic [3:0] op, input logic [3:0] b);
        return ((op == OP_DIV) || (op == OP_MOD)) && (b == 4'h0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// DEPTH-entry command FIFO with first-word fall-through read data.
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (empties the FIFO)
//   i_push   in   write i_wdata (ignored when full)
//   i_wdata  in   WIDTH-bit payload
//   i_pop    in   drop head entry (ignored when empty)
//   o_rdata  out  current head entry
//   o_level  out  occupancy, 0..DEPTH
// Push and pop in the same cycle both take effect and leave the level unchanged.
// ---------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && (r_level != LVL_FULL);
    assign w_do_pop  = i_pop  && (r_level != '0);

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; validity is tracked by
    // the pointers and level, so clearing the array would only cost hardware.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Queues {a, b, op} commands, feeds them one at a time to an external
// combinational 4-bit ALU and returns each result through a valid/ready port.
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           command handshake
//   in_a, in_b, in_op           command operands and opcode
//   alu_a, alu_b, alu_s         registered operands/opcode to the ALU
//   alu_y                       ALU result
//   out_valid/out_ready         result handshake
//   out_y, out_op, out_err      result, its opcode, divide/modulo-by-zero flag
//   fifo_level                  command FIFO occupancy
// One result per two cycles when out_ready stays high: EXEC captures the
// result, VALID hands it off and loads the next command in the same edge.
// ---------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic [3:0]               in_op,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [3:0]               alu_s,
    input  logic [3:0]               alu_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_y,
    output logic [3:0]               out_op,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_alu_a;
    logic [3:0]     r_alu_b;
    logic [3:0]     r_alu_s;
    logic [3:0]     r_out_y;
    logic [3:0]     r_out_op;
    logic           r_out_err;

    logic           w_push;
    logic           w_pop;
    logic           w_capture;
    logic           w_has_cmd;
    logic           w_zdiv;
    logic [LW-1:0]  w_level;
    cmd_t           w_head;

    // Ready depends only on the registered level (and reset), so a pop in the
    // same cycle never opens a slot early.
    assign in_ready  = rst_n && (w_level != LVL_FULL);
    assign w_push    = in_valid && in_ready;
    assign w_has_cmd = (w_level != '0);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({in_a, in_b, in_op}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_level (w_level)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_has_cmd) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_VALID;
            end
            ST_VALID: begin
                if (out_ready) begin
                    if (w_has_cmd) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_zdiv = is_zero_div(r_alu_s, r_alu_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_s   <= '0;
            r_out_y   <= '0;
            r_out_op  <= '0;
            r_out_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // ALU inputs change only when a command is popped, so they hold
            // steady through VALID and IDLE.
            if (w_pop) begin
                r_alu_a <= w_head.a;
                r_alu_b <= w_head.b;
                r_alu_s <= w_head.op;
            end
            if (w_capture) begin
                r_out_y   <= w_zdiv ? 4'h0 : alu_y;
                r_out_op  <= r_alu_s;
                r_out_err <= w_zdiv;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_s      = r_alu_s;
    assign out_valid  = (r_state == ST_VALID);
    assign out_y      = r_out_y;
    assign out_op     = r_out_op;
    assign out_err    = r_out_err;
    assign fifo_level = w_level;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports in_valid  input  1, in_ready  output  1  command handshake.
REQ-005 SHALL have ports in_a, in_b, in_op  input  4 each  operand A, operand B, ALU opcode.
REQ-006 SHALL have ports alu_a, alu_b, alu_s  output  4 each  registered operands/opcode driven into the combinational 4-bit ALU.
REQ-007 SHALL have port alu_y  input  4  ALU combinational result.
REQ-008 SHALL have ports out_valid  output  1, out_ready  input  1  result handshake.
REQ-009 SHALL have ports out_y  output  4, out_op  output  4, out_err  output  1  result, its opcode, divide/modulo-by-zero flag.
REQ-010 SHALL have port fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-011 SHALL buffer commands {a,b,op} in a DEPTH-entry FIFO; push when in_valid && in_ready.
REQ-012 SHALL drive in_ready = (fifo_level < DEPTH) from registered state only; full FIFO blocks push even if a pop occurs that cycle.
REQ-013 SHALL never pop an empty FIFO; pointers wrap modulo DEPTH.
REQ-014 SHALL run FSM states IDLE, EXEC, VALID.
REQ-015 IDLE: if fifo_level>0, pop head into alu_a/alu_b/alu_s, go EXEC; else stay.
REQ-016 EXEC: capture result into out_y, alu_s into out_op, set out_err, go VALID.
REQ-017 VALID: out_valid=1; on out_ready, pop next head and go EXEC if fifo_level>0, else go IDLE; without out_ready, hold.
REQ-018 out_y/out_op/out_err SHALL remain stable while out_valid && !out_ready.
REQ-019 out_valid SHALL be 1 only in VALID.
REQ-020 Latency: command accepted into empty FIFO at edge N with idle FSM -> out_valid high after edge N+2; sustained throughput one result per 2 cycles.
REQ-021 Push and pop in same cycle SHALL both take effect; fifo_level unchanged.
REQ-022 If alu_s is 4'b0011 (div) or 4'b0100 (mod) and alu_b==0, out_err SHALL be 1 and out_y 4'h0; otherwise out_err=0, out_y=alu_y.
REQ-023 All results are 4-bit, truncated by the ALU; no widening.
REQ-024 alu_a/alu_b/alu_s SHALL hold their last values outside EXEC.

Reset
REQ-025 rst_n low at a clk edge SHALL empty the FIFO, set FSM IDLE, clear out_valid, out_y, out_op, out_err, alu_a, alu_b, alu_s to 0.
REQ-026 Reset mid-operation SHALL discard in-flight and queued commands; no result emitted for them.
REQ-027 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.

Structure
REQ-028 Shared package alu_pkg SHALL hold opcode constants OP_ADD(0000)..OP_NAND(1111) and the FSM state encoding.
REQ-029 FIFO SHALL be sub-module alu_cmd_fifo (12-bit payload, DEPTH parameter, level output).
REQ-030 ALU SHALL be instantiated outside this block; no arithmetic beyond the zero-divisor check.

Verification
REQ-031 a=12,b=2,op=0000, out_ready=1 -> out_y=14, out_err=0, out_valid two edges after accept.
REQ-032 Stream ops 0001,0010,0011 with a=12,b=2 -> results 10,8,6 in order, one per 2 cycles.
REQ-033 a=12,b=0,op=0011 then op=0100 -> out_y=0, out_err=1 both; next op=0000 -> out_err=0.
REQ-034 out_ready=0, push 5 commands -> 1 in VALID, fifo_level=4, in_ready=0; release out_ready -> all results drain in order.
REQ-035 Full FIFO with simultaneous pop -> in_ready still 0 that cycle, push refused.
REQ-036 Assert rst_n=0 in EXEC with 3 queued -> next cycle out_valid=0, fifo_level=0, no further results.
